// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath width and immediate format select
package cpu_pkg;

  localparam int WIDTH = 32;

  // Encoding 3'd7 is deliberately left unassigned; it is the unsupported format.
  typedef enum logic [2:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_B  = 3'd2,
    IMM_U  = 3'd3,
    IMM_J  = 3'd4,
    IMM_Z  = 3'd5,
    IMM_SH = 3'd6
  } imm_src_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle
interface imm_gen_pipe_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int TAG_W = 32
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      instr_i;
  imm_src_e         imm_src_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] imm_o;
  logic [TAG_W-1:0] tag_o;
  logic             illegal_o;

  modport slave (
    input  in_valid_i, instr_i, imm_src_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, tag_o, illegal_o
  );

  modport master (
    output in_valid_i, instr_i, imm_src_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, tag_o, illegal_o
  );

endinterface

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate extraction for all formats
module imm_decode
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::WIDTH
) (
  input  logic [31:0]      instr,
  input  imm_src_e         imm_src,
  output logic [WIDTH-1:0] imm,
  output logic             illegal
);

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("imm_decode: WIDTH must be 32 or 64");
  end

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:  imm = WIDTH'($signed(instr[31:20]));
      IMM_S:  imm = WIDTH'($signed({instr[31:25], instr[11:7]}));
      IMM_B:  imm = WIDTH'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U:  imm = WIDTH'($signed({instr[31:12], 12'h000}));
      IMM_J:  imm = WIDTH'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_Z:  imm = WIDTH'(instr[19:15]);
      // RV64 shift amounts use one extra bit of the field.
      IMM_SH: imm = (WIDTH == 64) ? WIDTH'(instr[25:20]) : WIDTH'(instr[24:20]);
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate generator with a two-entry skid output buffer
module imm_gen_pipe
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int TAG_W = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  input logic           flush_i,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_e;

  buf_state_e       state;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] dec_imm;
  logic             dec_illegal;
  logic [WIDTH-1:0] main_imm,     skid_imm;
  logic [TAG_W-1:0] main_tag,     skid_tag;
  logic             main_illegal, skid_illegal;
  logic             accept;
  logic             emit;

  imm_decode #(.WIDTH(WIDTH)) u_decode (
    .instr   (bus.instr_i),
    .imm_src (bus.imm_src_i),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign accept = bus.in_valid_i && in_ready;
  assign emit   = out_valid && bus.out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= EMPTY;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      main_imm     <= '0;
      main_tag     <= '0;
      main_illegal <= 1'b0;
      skid_imm     <= '0;
      skid_tag     <= '0;
      skid_illegal <= 1'b0;
    end else if (flush_i) begin
      // Flush wins over a same-cycle accept; the offered instruction is dropped.
      state        <= EMPTY;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      main_imm     <= '0;
      main_tag     <= '0;
      main_illegal <= 1'b0;
      skid_imm     <= '0;
      skid_tag     <= '0;
      skid_illegal <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_imm     <= dec_imm;
            main_tag     <= bus.tag_i;
            main_illegal <= dec_illegal;
            out_valid    <= 1'b1;
            state        <= ONE;
          end
        end
        ONE: begin
          if (accept && !emit) begin
            skid_imm     <= dec_imm;
            skid_tag     <= bus.tag_i;
            skid_illegal <= dec_illegal;
            in_ready     <= 1'b0;
            state        <= FULL;
          end else if (accept && emit) begin
            main_imm     <= dec_imm;
            main_tag     <= bus.tag_i;
            main_illegal <= dec_illegal;
          end else if (emit) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain of main can happen.
          if (emit) begin
            main_imm     <= skid_imm;
            main_tag     <= skid_tag;
            main_illegal <= skid_illegal;
            in_ready     <= 1'b1;
            state        <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.imm_o       = main_imm;
  assign bus.tag_o       = main_tag;
  assign bus.illegal_o   = main_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.WIDTH(32), .TAG_W(32)) b32 ();
  imm_gen_pipe_if #(.WIDTH(64), .TAG_W(32)) b64 ();

  imm_gen_pipe #(.WIDTH(32), .TAG_W(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(b32)
  );
  imm_gen_pipe #(.WIDTH(64), .TAG_W(32)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(b64)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic offer32(input logic [31:0] instr, input imm_src_e src, input logic [31:0] tag);
    b32.in_valid_i = 1'b1;
    b32.instr_i    = instr;
    b32.imm_src_i  = src;
    b32.tag_i      = tag;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    flush = 1'b0;
    b32.in_valid_i = 1'b0; b32.instr_i = '0; b32.imm_src_i = IMM_I; b32.tag_i = '0; b32.out_ready_i = 1'b1;
    b64.in_valid_i = 1'b0; b64.instr_i = '0; b64.imm_src_i = IMM_I; b64.tag_i = '0; b64.out_ready_i = 1'b1;
    #2;
    n_checks++;
    if ({b32.out_valid_o, b32.in_ready_o, b32.illegal_o} !== 3'b010) begin
      n_fail++; $display("FAIL reset_flags32: got %b want 010", {b32.out_valid_o, b32.in_ready_o, b32.illegal_o});
    end
    n_checks++;
    if ({b32.imm_o, b32.tag_o} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data32: got %h want 0", {b32.imm_o, b32.tag_o});
    end
    n_checks++;
    if ({b64.out_valid_o, b64.in_ready_o, b64.imm_o} !== {2'b01, 64'h0}) begin
      n_fail++; $display("FAIL reset_64: got %b %b %h want 0 1 0", b64.out_valid_o, b64.in_ready_o, b64.imm_o);
    end
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] ins [4]  = '{32'hFFF00000, 32'h80000000, 32'hFE000F80, 32'h80000000};
    imm_src_e    srcs [4] = '{IMM_I, IMM_S, IMM_B, IMM_J};
    logic [31:0] exp [4]  = '{32'hFFFFFFFF, 32'hFFFFF800, 32'hFFFFFFFE, 32'hFFF00000};
    b32.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer32(ins[i], srcs[i], 32'h100 + i);
      tick;
      n_checks++;
      if ({b32.out_valid_o, b32.illegal_o, b32.in_ready_o} !== 3'b101) begin
        n_fail++; $display("FAIL b2b_flags[%0d]: got %b want 101", i, {b32.out_valid_o, b32.illegal_o, b32.in_ready_o});
      end
      n_checks++;
      if (b32.imm_o !== exp[i] || b32.tag_o !== 32'h100 + i) begin
        n_fail++; $display("FAIL b2b_data[%0d]: got imm %h tag %h want %h %h", i, b32.imm_o, b32.tag_o, exp[i], 32'h100 + i);
      end
    end
    b32.in_valid_i = 1'b0;
    tick;
    n_checks++;
    if (b32.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: got out_valid %b want 0", b32.out_valid_o);
    end
  endtask

  task automatic test_formats32;
    logic [31:0] ins [3]  = '{32'hABCDE000, 32'h03F00000, 32'h800F8000};
    imm_src_e    srcs [3] = '{IMM_U, IMM_SH, IMM_Z};
    logic [31:0] exp [3]  = '{32'hABCDE000, 32'h0000001F, 32'h0000001F};
    b32.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer32(ins[i], srcs[i], 32'h200 + i);
      tick;
      n_checks++;
      if (b32.out_valid_o !== 1'b1 || b32.illegal_o !== 1'b0 || b32.imm_o !== exp[i]) begin
        n_fail++; $display("FAIL fmt32[%0d]: got v%b ill%b imm %h want imm %h", i, b32.out_valid_o, b32.illegal_o, b32.imm_o, exp[i]);
      end
    end
    b32.in_valid_i = 1'b0;
    tick;
  endtask

  task automatic test_width64;
    logic [31:0] ins [3]  = '{32'hABCDE000, 32'h03F00000, 32'h800F8000};
    imm_src_e    srcs [3] = '{IMM_U, IMM_SH, IMM_Z};
    logic [63:0] exp [3]  = '{64'hFFFFFFFF_ABCDE000, 64'h00000000_0000003F, 64'h00000000_0000001F};
    b64.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b64.in_valid_i = 1'b1;
      b64.instr_i    = ins[i];
      b64.imm_src_i  = srcs[i];
      b64.tag_i      = 32'h300 + i;
      tick;
      n_checks++;
      if (b64.out_valid_o !== 1'b1 || b64.imm_o !== exp[i] || b64.tag_o !== 32'h300 + i) begin
        n_fail++; $display("FAIL fmt64[%0d]: got v%b imm %h tag %h want imm %h", i, b64.out_valid_o, b64.imm_o, b64.tag_o, exp[i]);
      end
    end
    b64.in_valid_i = 1'b0;
    tick;
    n_checks++;
    if (b64.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL fmt64_drain: got out_valid %b want 0", b64.out_valid_o);
    end
  endtask

  task automatic test_stall;
    b32.out_ready_i = 1'b0;
    offer32(32'h00100000, IMM_I, 32'hA1);
    tick;
    n_checks++;
    if (b32.in_ready_o !== 1'b1 || b32.imm_o !== 32'h1 || b32.tag_o !== 32'hA1) begin
      n_fail++; $display("FAIL stall_one: got rdy %b imm %h tag %h want 1 1 a1", b32.in_ready_o, b32.imm_o, b32.tag_o);
    end
    offer32(32'h00200000, IMM_I, 32'hA2);
    tick;
    n_checks++;
    if (b32.in_ready_o !== 1'b0 || b32.imm_o !== 32'h1 || b32.tag_o !== 32'hA1) begin
      n_fail++; $display("FAIL stall_full: got rdy %b imm %h tag %h want 0 1 a1", b32.in_ready_o, b32.imm_o, b32.tag_o);
    end
    offer32(32'h00300000, IMM_I, 32'hA3);
    tick;
    n_checks++;
    if (b32.in_ready_o !== 1'b0 || b32.out_valid_o !== 1'b1 || b32.imm_o !== 32'h1 || b32.tag_o !== 32'hA1) begin
      n_fail++; $display("FAIL stall_hold: got rdy %b v %b imm %h tag %h want 0 1 1 a1", b32.in_ready_o, b32.out_valid_o, b32.imm_o, b32.tag_o);
    end
    b32.out_ready_i = 1'b1;
    tick;
    n_checks++;
    if (b32.in_ready_o !== 1'b1 || b32.imm_o !== 32'h2 || b32.tag_o !== 32'hA2) begin
      n_fail++; $display("FAIL stall_rel1: got rdy %b imm %h tag %h want 1 2 a2", b32.in_ready_o, b32.imm_o, b32.tag_o);
    end
    tick;
    n_checks++;
    if (b32.out_valid_o !== 1'b1 || b32.imm_o !== 32'h3 || b32.tag_o !== 32'hA3) begin
      n_fail++; $display("FAIL stall_rel2: got v %b imm %h tag %h want 1 3 a3", b32.out_valid_o, b32.imm_o, b32.tag_o);
    end
    b32.in_valid_i = 1'b0;
    tick;
    n_checks++;
    if (b32.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_drain: got out_valid %b want 0", b32.out_valid_o);
    end
  endtask

  task automatic test_flush;
    b32.out_ready_i = 1'b0;
    offer32(32'h00400000, IMM_I, 32'hB1);
    tick;
    offer32(32'h00500000, IMM_I, 32'hB2);
    tick;
    offer32(32'h00600000, IMM_I, 32'hB3);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    b32.in_valid_i = 1'b0;
    n_checks++;
    if (b32.out_valid_o !== 1'b0 || b32.in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_full: got v %b rdy %b want 0 1", b32.out_valid_o, b32.in_ready_o);
    end
    b32.out_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_checks++;
      if (b32.out_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL flush_full_quiet[%0d]: got out_valid %b want 0", i, b32.out_valid_o);
      end
    end
    b32.out_ready_i = 1'b0;
    offer32(32'h00700000, IMM_I, 32'hB4);
    tick;
    offer32(32'h00800000, IMM_I, 32'hB5);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    b32.in_valid_i = 1'b0;
    b32.out_ready_i = 1'b1;
    n_checks++;
    if (b32.out_valid_o !== 1'b0 || b32.in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_one: got v %b rdy %b want 0 1", b32.out_valid_o, b32.in_ready_o);
    end
    tick;
    n_checks++;
    if (b32.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_one_quiet: got out_valid %b want 0", b32.out_valid_o);
    end
  endtask

  task automatic test_illegal;
    b32.out_ready_i = 1'b1;
    offer32(32'hFFFFFFFF, imm_src_e'(3'd7), 32'h77);
    tick;
    n_checks++;
    if (b32.out_valid_o !== 1'b1 || b32.illegal_o !== 1'b1 || b32.imm_o !== 32'h0 || b32.tag_o !== 32'h77) begin
      n_fail++; $display("FAIL illegal: got v %b ill %b imm %h tag %h want 1 1 0 77", b32.out_valid_o, b32.illegal_o, b32.imm_o, b32.tag_o);
    end
    offer32(32'h00500000, IMM_I, 32'h78);
    tick;
    n_checks++;
    if (b32.illegal_o !== 1'b0 || b32.imm_o !== 32'h5 || b32.tag_o !== 32'h78) begin
      n_fail++; $display("FAIL illegal_next: got ill %b imm %h tag %h want 0 5 78", b32.illegal_o, b32.imm_o, b32.tag_o);
    end
    b32.in_valid_i = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    b32.out_ready_i = 1'b0;
    offer32(32'h00700000, IMM_I, 32'h55);
    tick;
    b32.in_valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({b32.out_valid_o, b32.in_ready_o, b32.illegal_o} !== 3'b010 || b32.imm_o !== 32'h0 || b32.tag_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid: got v %b rdy %b ill %b imm %h tag %h want 0 1 0 0 0",
                         b32.out_valid_o, b32.in_ready_o, b32.illegal_o, b32.imm_o, b32.tag_o);
    end
    #1;
    rst = 1'b0;
    b32.out_ready_i = 1'b1;
    offer32(32'h00900000, IMM_I, 32'h66);
    tick;
    n_checks++;
    if (b32.out_valid_o !== 1'b1 || b32.imm_o !== 32'h9 || b32.tag_o !== 32'h66) begin
      n_fail++; $display("FAIL reset_mid_next: got v %b imm %h tag %h want 1 9 66", b32.out_valid_o, b32.imm_o, b32.tag_o);
    end
    b32.in_valid_i = 1'b0;
    tick;
    n_checks++;
    if (b32.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_drain: got out_valid %b want 0", b32.out_valid_o);
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_formats32;
    test_width64;
    test_stall;
    test_flush;
    test_illegal;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter WIDTH, default cpu_pkg::WIDTH (32), datapath width; legal values are 32 and 64 only.
REQ-002 Parameter TAG_W, default 32, width of the sideband tag (PC or ROB index) carried with each instruction.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 flush_i  input  1  discards all buffered entries.
REQ-006 in_valid_i  input  1  instruction offered.
REQ-007 in_ready_o  output  1  block can accept an instruction this cycle.
REQ-008 instr_i  input  32  raw instruction word.
REQ-009 imm_src_i  input  imm_src  immediate format select.
REQ-010 tag_i  input  TAG_W  sideband tag.
REQ-011 out_valid_o  output  1  imm_o, tag_o and illegal_o are valid.
REQ-012 out_ready_i  input  1  consumer accepts the output.
REQ-013 imm_o  output  WIDTH  generated immediate.
REQ-014 tag_o  output  TAG_W  tag of the presented entry.
REQ-015 illegal_o  output  1  presented entry had an unsupported imm_src.

Function
REQ-016 Accept: in_valid_i && in_ready_o; emit: out_valid_o && out_ready_i.
REQ-017 Storage: main output register plus one skid register; states EMPTY, ONE (main only), FULL (main and skid).
REQ-018 in_ready_o SHALL be registered and equal to 1 in EMPTY and ONE, 0 in FULL.
REQ-019 Transitions:
- EMPTY + accept -> ONE.
- ONE + accept without emit -> FULL.
- ONE + emit without accept -> EMPTY.
- ONE + accept and emit -> ONE, new entry in main.
- FULL + emit -> ONE, skid moves to main.
- All other cases hold state.
REQ-020 Latency SHALL be one cycle: an entry accepted at edge N is presented from edge N+1 when the block was EMPTY.
REQ-021 With out_ready_i held high, throughput SHALL be one entry per cycle.
REQ-022 Entries SHALL be emitted in acceptance order, each with its own tag.
REQ-023 While out_valid_o=1 and out_ready_i=0, imm_o, tag_o and illegal_o SHALL stay stable.
REQ-024 Immediate formats (bit fields of instr_i); every format except Z and SH sign-extends from instr[31] to WIDTH:
- I: [31:20].
- S: {[31:25],[11:7]}.
- B: {[31],[7],[30:25],[11:8],0}.
- U: {[31:12],12'h000}.
- J: {[31],[19:12],[20],[30:21],0}.
REQ-025 Z (CSR zimm) SHALL zero-extend [19:15]; SH SHALL zero-extend [24:20] when WIDTH=32 and [25:20] when WIDTH=64.
REQ-026 An unsupported imm_src SHALL still be buffered, with imm_o=0 and illegal_o=1; for supported formats illegal_o=0.
REQ-027 Flush at edge N:
- Both entries SHALL be cleared, giving EMPTY and out_valid_o=0 after edge N.
- Flush SHALL take priority over an accept in the same cycle; that instruction is dropped.
- in_ready_o SHALL be 1 after edge N.

Reset
REQ-028 On rst_i=1, immediately and independent of clk_i: state EMPTY, out_valid_o=0, in_ready_o=1, imm_o=0, tag_o=0, illegal_o=0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries; the first accept is possible on the first rising edge after rst_i deasserts.

Structure
REQ-030 cpu_pkg SHALL hold WIDTH and the imm_src enum, 3 bits wide: IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3, IMM_J=4, IMM_Z=5, IMM_SH=6; value 7 is unsupported.
REQ-031 The combinational decode SHALL be a sub-module imm_decode (instr, imm_src -> imm, illegal), parametrised by WIDTH and instantiated once ahead of the buffer.

Verification
REQ-032 WIDTH=32, out_ready_i=1, back-to-back I 12'hFFF, S 12'h800, B 13'h1FFE, J 21'h100000 -> one cycle later, one per cycle: FFFFFFFF, FFFFF800, FFFFFFFE, FFF00000, tags in order.
REQ-033 WIDTH=64 -> the following outputs:
- U 20'hABCDE -> FFFFFFFF_ABCDE000.
- SH with instr[25:20]=6'h3F -> 00000000_0000003F.
- Z with instr[19:15]=5'h1F -> 00000000_0000001F.
REQ-034 out_ready_i=0 for 3 cycles while 3 instructions are offered -> in_ready_o falls after the 2nd accept; the 3rd is held until out_ready_i=1, then all 3 emerge in order with no loss or duplication.
REQ-035 State FULL, flush_i=1 together with in_valid_i=1 -> out_valid_o=0 next cycle and no entry emerges from the offered instruction.
REQ-036 imm_src=7 -> illegal_o=1, imm_o=0; rst_i pulsed between clock edges while in ONE -> outputs go to reset values at once, and the next instruction after release is presented correctly.
